x_reg_stream: RTL and testbench
===============================

Name: x_reg_stream

Overview:
- Parametrised successor to the X vector register file feeding the systolic array.
- Keeps the indexed write/read port: EN, WRITE, IDX, DIN, DOUT.
- Adds a sequencer that streams a contiguous run of entries (wrapping modulo DEPTH) to the array edge over a valid/ready handshake.
- Sits between the host load path and the row-input skew logic of the array.

Parameters:
DATA_W, 16, entry width in bits
DEPTH, 32, number of entries (power of two, >=2)
IDX_W, $clog2(DEPTH), index width
LEN_W, $clog2(DEPTH)+1, stream length field width

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
EN  input  1  global enable; when 0 all state holds
WRITE  input  1  1 = write DIN to entry IDX; 0 = read entry IDX to DOUT
IDX  input  IDX_W  random-access index
DIN  input  DATA_W  write data
DOUT  output  DATA_W  registered random-read data
START  input  1  begin stream (sampled only when idle)
BASE  input  IDX_W  first entry of stream
LEN  input  LEN_W  number of beats
BUSY  output  1  stream in progress
S_VALID  output  1  stream beat valid
S_READY  input  1  consumer ready
S_DATA  output  DATA_W  stream beat data
S_LAST  output  1  marks final beat
DONE  output  1  one-cycle pulse after stream completes

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is synchronous and active-high.
- Reset (RST=1 at an edge, overrides EN): all entries = 0; DOUT=0, S_DATA=0, S_VALID=0, S_LAST=0, BUSY=0, DONE=0; FSM -> IDLE. Reset mid-stream aborts with no DONE pulse.
- EN=0: no memory write, DOUT/S_* hold, FSM holds, START ignored, handshake ignored. DONE is forced to 0 while EN=0.
- Write: EN=1 and WRITE=1 -> mem[IDX] <= DIN at the edge. DOUT holds.
- Read: EN=1 and WRITE=0 -> DOUT <= mem[IDX] at the edge (1-cycle latency). A read of an entry written on the previous edge returns the new value.
- The random port is fully independent of the stream and is usable while BUSY.
- FSM states: IDLE, STREAM.
- IDLE, EN=1, START=1, LEN!=0: ptr <= BASE, remaining <= LEN, S_DATA <= mem[BASE], S_VALID <= 1, S_LAST <= (LEN==1), BUSY <= 1, then -> STREAM. The first beat is visible the cycle after START.
- IDLE, EN=1, START=1, LEN==0: no beats, BUSY stays 0, DONE=1 next cycle.
- STREAM: a handshake occurs when EN=1, S_VALID=1 and S_READY=1.
  - Handshake with remaining>1: ptr <= ptr+1 (mod DEPTH), S_DATA <= mem[ptr+1], S_LAST <= (remaining==2), remaining decrements. No bubble: one beat per cycle under constant S_READY.
  - Handshake on the S_LAST beat: S_VALID <= 0, S_LAST <= 0, BUSY <= 0, DONE <= 1 for one cycle, -> IDLE.
- S_VALID=1 and S_READY=0: S_DATA and S_LAST hold stable, even if the presented entry is overwritten.
- Write/stream bypass: if a write on the same edge targets the entry being loaded into S_DATA, S_DATA takes DIN (write-first).
- LEN > DEPTH is legal: the pointer wraps and entries repeat. BASE+LEN past DEPTH-1 also wraps to 0.
- START while BUSY is ignored. START in the same cycle as the final handshake is ignored; START is re-accepted from the DONE cycle.
- DONE is a single-cycle pulse and is not gated by S_READY.

Test Plan:
- Reset then sequential write i+1 to entries 0..31, then read idx 0..31 -> DOUT = 1..32, each one cycle after its IDX is presented. Before the writes, reads return 0.
- Insert write i*2 to entries 10..20, then full read -> entries 10..20 = 20..40, others unchanged.
- BASE=28, LEN=8, S_READY=1 constant, memory preloaded with idx+1 -> 8 consecutive beats S_DATA = 29,30,31,32,1,2,3,4. S_LAST on beat 8; BUSY falls and DONE pulses on the cycle after.
- BASE=0, LEN=4, S_READY toggling 1,0,0,1,... -> S_DATA stable during stalls. Exactly 4 handshakes occur, values 1..4 in order. A write to entry 0 during the first stall does not change the presented beat.
- During a stream, write DIN=0xABCD to the entry loaded on the same edge -> that beat carries 0xABCD. Separately, START with LEN=0 -> no S_VALID, DONE one-cycle pulse.
- Assert RST mid-stream (beat 3 of 10) -> next cycle S_VALID=0, BUSY=0, no DONE, all entries read 0. EN=0 for 5 cycles mid-stream -> all outputs frozen, and the stream resumes unchanged.

Source files
------------

// File: rtl/x_reg_stream.sv
// x_reg_stream: indexed X register file plus a wrapping valid/ready stream sequencer
module x_reg_stream #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int LEN_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              write,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  input  logic              start,
  input  logic [IDX_W-1:0]  base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DATA_W-1:0] s_data,
  output logic              s_last,
  output logic              done
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0] ptr, ld_idx;
  logic [LEN_W-1:0] rem;
  logic [DATA_W-1:0] ld_val;
  logic done_r, go, hs, fin;
  always_comb begin
    go = en && state == IDLE && start && len != '0;
    hs = en && state == STREAM && s_valid && s_ready;
    fin = hs && s_last;
    ld_idx = state == IDLE ? base : ptr + 1'b1;
    // write-first: a same-edge write to the entry being loaded wins
    ld_val = (en && write && idx == ld_idx) ? din : mem[ld_idx];
    state_nx = go ? STREAM : fin ? IDLE : state;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      dout <= '0;
      s_data <= '0;
      s_valid <= 1'b0;
      s_last <= 1'b0;
      busy <= 1'b0;
      done_r <= 1'b0;
      ptr <= '0;
      rem <= '0;
    end else if (en) begin
      if (write) mem[idx] <= din;
      else dout <= mem[idx];
      done_r <= fin || (state == IDLE && start && len == '0);
      if (go) begin
        ptr <= base;
        rem <= len;
        s_data <= ld_val;
        s_valid <= 1'b1;
        s_last <= len == LEN_W'(1);
        busy <= 1'b1;
      end else if (fin) begin
        s_valid <= 1'b0;
        s_last <= 1'b0;
        busy <= 1'b0;
      end else if (hs) begin
        ptr <= ld_idx;
        s_data <= ld_val;
        s_last <= rem == LEN_W'(2);
        rem <= rem - 1'b1;
      end
    end else begin
      done_r <= 1'b0;
    end
  end
  assign done = done_r & en;
endmodule

// File: tb/tb_x_reg_stream.sv
// tb_x_reg_stream: directed tests of the random port and stream sequencer of x_reg_stream
module tb_x_reg_stream;
  logic clk = 0, rst, en, write, start, s_ready;
  logic [4:0] idx, base;
  logic [5:0] len;
  logic [15:0] din;
  logic [15:0] dout, s_data;
  logic busy, s_valid, s_last, done;
  int vectors = 0, miscompares = 0;

  x_reg_stream dut (
    .clk(clk), .rst(rst), .en(en), .write(write), .idx(idx), .din(din), .dout(dout),
    .start(start), .base(base), .len(len), .busy(busy), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int i, input logic [15:0] d);
    write = 1; idx = 5'(i); din = d;
    tick;
    write = 0;
  endtask

  task automatic rd(input int i);
    write = 0; idx = 5'(i);
    tick;
  endtask

  task automatic preload;
    for (int i = 0; i < 32; i++) wr(i, 16'(i + 1));
  endtask

  task automatic begin_stream(input int b, input int l);
    base = 5'(b); len = 6'(l); start = 1;
    tick;
    start = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    tick; tick;
    rst = 0;
    vectors++;
    if ({dout, s_data, s_valid, s_last, busy, done} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0", {dout, s_data, s_valid, s_last, busy, done});
    end
    for (int i = 0; i < 32; i++) begin
      rd(i);
      vectors++;
      if (dout !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_read[%0d] got %h want 0000", i, dout);
      end
    end
  endtask

  task automatic test_seq_write_read;
    preload;
    for (int i = 0; i < 32; i++) begin
      rd(i);
      vectors++;
      if (dout !== 16'(i + 1)) begin
        miscompares++;
        $display("FAIL seq_read[%0d] got %h want %h", i, dout, 16'(i + 1));
      end
    end
  endtask

  task automatic test_insert_write;
    logic [15:0] exp;
    for (int i = 10; i <= 20; i++) wr(i, 16'(i * 2));
    for (int i = 0; i < 32; i++) begin
      rd(i);
      exp = (i >= 10 && i <= 20) ? 16'(i * 2) : 16'(i + 1);
      vectors++;
      if (dout !== exp) begin
        miscompares++;
        $display("FAIL insert_read[%0d] got %h want %h", i, dout, exp);
      end
    end
    preload;
  endtask

  task automatic test_stream_wrap;
    logic [15:0] exp [8] = '{16'd29, 16'd30, 16'd31, 16'd32, 16'd1, 16'd2, 16'd3, 16'd4};
    s_ready = 1;
    begin_stream(28, 8);
    for (int b = 0; b < 8; b++) begin
      vectors++;
      if ({s_valid, busy, done, s_last, s_data} !== {1'b1, 1'b1, 1'b0, b == 7, exp[b]}) begin
        miscompares++;
        $display("FAIL wrap_beat[%0d] got v%b b%b d%b l%b %h want v1 b1 d0 l%b %h",
                 b, s_valid, busy, done, s_last, s_data, b == 7, exp[b]);
      end
      tick;
    end
    vectors++;
    if ({s_valid, busy, done} !== 3'b001) begin
      miscompares++;
      $display("FAIL wrap_end got v%b b%b d%b want v0 b0 d1", s_valid, busy, done);
    end
    tick;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_done_pulse got %b want 0", done);
    end
  endtask

  task automatic test_stall;
    int n = 0;
    logic stalled = 0;
    logic [15:0] prev = 0;
    begin_stream(0, 4);
    for (int c = 0; c < 30 && busy; c++) begin
      s_ready = (c % 3 == 2);
      write = (c == 0); idx = 0; din = 16'h7777;
      if (stalled) begin
        vectors++;
        if (s_data !== prev) begin
          miscompares++;
          $display("FAIL stall_hold cycle %0d got %h want %h", c, s_data, prev);
        end
      end
      if (s_valid && s_ready) begin
        vectors++;
        if (s_data !== 16'(n + 1)) begin
          miscompares++;
          $display("FAIL stall_beat[%0d] got %h want %h", n, s_data, 16'(n + 1));
        end
        n++;
      end
      stalled = s_valid && !s_ready;
      prev = s_data;
      tick;
    end
    write = 0;
    vectors++;
    if (n !== 4 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_count got %0d done %b want 4 done 1", n, done);
    end
    s_ready = 0;
    wr(0, 16'd1);
  endtask

  task automatic test_bypass;
    s_ready = 1;
    begin_stream(4, 3);
    write = 1; idx = 5; din = 16'hABCD;
    vectors++;
    if (s_data !== 16'd5) begin
      miscompares++;
      $display("FAIL bypass_beat0 got %h want 0005", s_data);
    end
    tick;
    write = 0;
    vectors++;
    if (s_data !== 16'hABCD) begin
      miscompares++;
      $display("FAIL bypass_beat1 got %h want abcd", s_data);
    end
    tick;
    vectors++;
    if ({s_last, s_data} !== {1'b1, 16'd7}) begin
      miscompares++;
      $display("FAIL bypass_beat2 got l%b %h want l1 0007", s_last, s_data);
    end
    tick;
    vectors++;
    if ({busy, done} !== 2'b01) begin
      miscompares++;
      $display("FAIL bypass_end got b%b d%b want b0 d1", busy, done);
    end
    s_ready = 0;
    wr(5, 16'd6);
  endtask

  task automatic test_len_zero;
    begin_stream(3, 0);
    vectors++;
    if ({s_valid, busy, done} !== 3'b001) begin
      miscompares++;
      $display("FAIL len0 got v%b b%b d%b want v0 b0 d1", s_valid, busy, done);
    end
    tick;
    vectors++;
    if ({s_valid, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL len0_pulse got v%b d%b want v0 d0", s_valid, done);
    end
  endtask

  task automatic test_reset_mid;
    s_ready = 1;
    begin_stream(0, 10);
    tick; tick;
    vectors++;
    if (s_data !== 16'd3) begin
      miscompares++;
      $display("FAIL rstmid_beat3 got %h want 0003", s_data);
    end
    rst = 1;
    tick;
    rst = 0;
    vectors++;
    if ({s_valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL rstmid_abort got v%b b%b d%b want 000", s_valid, busy, done);
    end
    tick;
    vectors++;
    if ({s_valid, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_nodone got v%b d%b want 00", s_valid, done);
    end
    for (int i = 0; i < 32; i++) begin
      rd(i);
      vectors++;
      if (dout !== 16'h0) begin
        miscompares++;
        $display("FAIL rstmid_read[%0d] got %h want 0000", i, dout);
      end
    end
    s_ready = 0;
    preload;
  endtask

  task automatic test_en_freeze;
    s_ready = 1;
    idx = 31;
    begin_stream(8, 6);
    tick;
    en = 0; start = 1; write = 1; idx = 3; din = 16'hDEAD;
    for (int c = 0; c < 5; c++) begin
      tick;
      vectors++;
      if ({s_valid, busy, done, s_last, s_data, dout} !== {4'b1100, 16'd10, 16'd32}) begin
        miscompares++;
        $display("FAIL freeze[%0d] got v%b b%b d%b l%b %h %h want v1 b1 d0 l0 000a 0020",
                 c, s_valid, busy, done, s_last, s_data, dout);
      end
    end
    en = 1; start = 0; write = 0; idx = 31;
    for (int b = 0; b < 5; b++) begin
      vectors++;
      if ({s_valid, s_last, s_data} !== {1'b1, b == 4, 16'(10 + b)}) begin
        miscompares++;
        $display("FAIL resume_beat[%0d] got v%b l%b %h want v1 l%b %h",
                 b, s_valid, s_last, s_data, b == 4, 16'(10 + b));
      end
      tick;
    end
    vectors++;
    if ({busy, done} !== 2'b01) begin
      miscompares++;
      $display("FAIL resume_end got b%b d%b want b0 d1", busy, done);
    end
    s_ready = 0;
    rd(3);
    vectors++;
    if (dout !== 16'd4) begin
      miscompares++;
      $display("FAIL freeze_nowrite got %h want 0004", dout);
    end
  endtask

  initial begin
    rst = 1; en = 1; write = 0; start = 0; s_ready = 0;
    idx = 0; base = 0; len = 0; din = 0;
    test_reset;
    test_seq_write_read;
    test_insert_write;
    test_stream_wrap;
    test_stall;
    test_bypass;
    test_len_zero;
    test_reset_mid;
    test_en_freeze;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
